// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state enums and width defaults for the sequential ALU.
// The DIV_RUN state only exists when ALU_DIV_EN is defined.
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int SHAMT_DEF = 4;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4,
    OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7, OP_MUL = 4'd8, OP_DIV = 4'd9
  } op_t;
  typedef enum logic [2:0] {
    IDLE, EXEC, MUL_RUN,
`ifdef ALU_DIV_EN
    DIV_RUN,
`endif
    DONE
  } state_t;
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: shift-add multiplier and restoring divider sharing one counter and hi/lo shift registers.
// After W steps: MUL -> {hi,lo} = a*b; DIV -> lo = quotient, hi = remainder (b==0 gives all-ones, a).
module alu_iter_unit
  import alu_pkg::*;
#(parameter int W = DATA_W) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         last
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0] add, sub;
  assign last = cnt_q == CW'(W);
  assign lo = lo_q;
  assign hi = hi_q;
  always_comb begin
    add = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    sub = {hi_q, lo_q[W-1]} - {1'b0, m_q};
    hi_d = hi_q;
    lo_d = lo_q;
    m_d = m_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      hi_d = '0;
      lo_d = div ? a : b;
      m_d = div ? b : a;
      div_d = div;
      cnt_d = '0;
    end else if (!last) begin
      cnt_d = cnt_q + 1'b1;
      // restoring step: keep the subtraction only when it did not borrow
      if (!div_q) {hi_d, lo_d} = {add, lo_q[W-1:1]};
      else if (!sub[W]) {hi_d, lo_d} = {sub[W-1:0], lo_q[W-2:0], 1'b1};
      else {hi_d, lo_d} = {hi_q[W-2:0], lo_q, 1'b0};
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q <= '0;
      div_q <= 1'b0;
      cnt_q <= CW'(W);
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q <= m_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with 1-cycle logic/arith ops and iterative MUL (and DIV when ALU_DIV_EN is defined).
// Operands are latched on an accepted start; results and flags are registered on entry to DONE.
module alu_seq
  import alu_pkg::*;
#(parameter int W = DATA_W, parameter int SHAMT_W = SHAMT_DEF) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] remainder,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_n,
  output logic         flag_v,
  output logic         err
);
  state_t state_q, state_d;
  op_t op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, rem_q, rem_d, r, rm, it_lo, it_hi;
  logic [3:0] fl_q, fl_d;
  logic err_q, err_d, accept, cap, ill, dz, c, v, is_div, it_last;
  logic [W:0] sum, diff, shl, shr;
  logic [SHAMT_W-1:0] sh;
  assign accept = state_q == IDLE && start;
`ifdef ALU_DIV_EN
  assign is_div = op == OP_DIV;
`else
  assign is_div = 1'b0;
`endif
  alu_iter_unit #(.W(W)) u_iter (
    .clk(clk), .reset(reset), .load(accept), .div(is_div), .a(a), .b(b),
    .lo(it_lo), .hi(it_hi), .last(it_last)
  );
  always_comb begin
    sh = b_q[SHAMT_W-1:0];
    sum = {1'b0, a_q} + {1'b0, b_q};
    diff = {1'b0, a_q} - {1'b0, b_q};
    shl = {1'b0, a_q} << sh;
    shr = {a_q, 1'b0} >> sh;
    r = '0;
    rm = '0;
    c = 1'b0;
    v = 1'b0;
    ill = 1'b0;
    dz = 1'b0;
    cap = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = start ? (op == OP_MUL ? MUL_RUN : EXEC) : IDLE;
`ifdef ALU_DIV_EN
        if (start && is_div) state_d = DIV_RUN;
`endif
      end
      EXEC: begin
        state_d = DONE;
        cap = 1'b1;
        case (op_q)
          OP_ADD: begin
            r = sum[W-1:0];
            c = sum[W];
            v = a_q[W-1] == b_q[W-1] && r[W-1] != a_q[W-1];
          end
          OP_SUB: begin
            r = diff[W-1:0];
            c = diff[W];
            v = a_q[W-1] != b_q[W-1] && r[W-1] != a_q[W-1];
          end
          OP_AND: r = a_q & b_q;
          OP_OR:  r = a_q | b_q;
          OP_XOR: r = a_q ^ b_q;
          OP_NOT: r = ~a_q;
          OP_SHL: begin
            r = shl[W-1:0];
            c = shl[W];
          end
          OP_SHR: begin
            r = shr[W:1];
            c = shr[0];
          end
          default: ill = 1'b1;
        endcase
      end
      MUL_RUN: begin
        r = it_lo;
        c = |it_hi;
        state_d = it_last ? DONE : MUL_RUN;
        cap = it_last;
      end
`ifdef ALU_DIV_EN
      DIV_RUN: begin
        r = it_lo;
        rm = it_hi;
        dz = b_q == '0;
        state_d = it_last ? DONE : DIV_RUN;
        cap = it_last;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    op_d = accept ? op_t'(op) : op_q;
    a_d = accept ? a : a_q;
    b_d = accept ? b : b_q;
    res_d = cap ? r : res_q;
    rem_d = cap ? rm : rem_q;
    fl_d = cap ? {!ill && r == '0, c, !ill && r[W-1], v} : fl_q;
    err_d = cap ? ill || dz : err_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q <= OP_ADD;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      rem_q <= '0;
      fl_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      rem_q <= rem_d;
      fl_q <= fl_d;
      err_q <= err_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign result = res_q;
  assign remainder = rem_q;
  assign {flag_z, flag_c, flag_n, flag_v} = fl_q;
  assign err = err_q;
endmodule
